ftdi_rx_packet_parser: RTL and testbench
========================================

Name: ftdi_rx_packet_parser

Overview:
- Sits downstream of the FTDI host interface's read queue and upstream of its 1 KiB packet write queue.
- Pops host bytes and hunts for framed packets: sync, length, payload, checksum.
- Streams each payload byte into the packet queue.
- On a good checksum it pulses load_1k so the packet is padded and transmitted. On any error it pulses a queue clear so partial data never reaches the laser link.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 1024, largest legal payload length; must equal the packet queue depth.
- TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between bytes inside a frame before abort.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new rdreq is issued; a byte already in flight is still captured.
- rdq_empty  input  1  host read queue empty.
- data_rd  input  8  host read queue output; valid the cycle after rdreq (normal-mode FIFO).
- rdreq  output  1  pop host read queue.
- wrq_full  input  1  packet write queue full.
- data_wr  output  8  payload byte to packet queue.
- wrreq  output  1  push data_wr (one-cycle strobe).
- load_1k  output  1  one-cycle pulse: packet complete and checksum good.
- wr_clear  output  1  one-cycle pulse: discard partial packet in packet queue.
- busy  output  1  high in any state other than HUNT.
- pkt_count  output  16  good packets, saturating at 16'hFFFF.
- err_count  output  16  aborted packets, saturating at 16'hFFFF.

Behaviour:
- Interface decided: one clock; reset is synchronous and active-high; ports named clock and reset.
- Reset values:
  - rdreq, wrreq, load_1k, wr_clear, busy = 0; data_wr = 0; counters = 0.
  - State = HUNT, byte-in-flight flag = 0, len = 0, idx = 0, sum = 0, timer = 0.
- Fetch rule: rdreq=1 only when all of the following hold:
  - enable=1 and rdq_empty=0;
  - no byte in flight;
  - state in {HUNT, LEN_LO, LEN_HI, PAYLOAD, CSUM};
  - in PAYLOAD, additionally wrq_full=0.
- Fetch timing: in-flight flag is set the cycle after rdreq, and data_rd is captured in that cycle. Peak rate is 1 byte per 2 cycles.
- HUNT: captured byte == SYNC_BYTE -> LEN_LO with sum=0 and idx=0. Any other byte is dropped silently and does not count as an error.
- LEN_LO: capture len[7:0] -> LEN_HI.
- LEN_HI: capture len[10:8] = byte[2:0].
  - If byte[7:3] != 0, or len == 0, or len > MAX_LEN -> ERR.
  - Otherwise -> PAYLOAD.
- PAYLOAD: each captured byte drives data_wr=byte and wrreq=1 in the same cycle; sum += byte (mod 256); idx += 1. When idx reaches len -> CSUM.
- CSUM: captured byte == sum -> GOOD, otherwise -> ERR.
- GOOD: load_1k=1 for one cycle, pkt_count+1 -> HUNT.
- ERR: wr_clear=1 for one cycle, err_count+1 -> HUNT. No load_1k is issued.
- Timeout:
  - timer counts cycles with no captured byte while in LEN_LO, LEN_HI, PAYLOAD or CSUM, and resets on each capture.
  - timer == TIMEOUT_CYCLES-1 -> ERR.
  - A capture in the same cycle wins over the timeout.
- Backpressure: wrq_full only blocks rdreq. A byte already in flight is still pushed. The packet queue is sized so len <= MAX_LEN never overflows it.
- A SYNC_BYTE value inside a payload is treated as data; there is no resynchronisation mid-frame.
- Counters saturate and never wrap.
- reset mid-frame:
  - returns to HUNT next cycle; any in-flight byte is discarded;
  - no wr_clear pulse (the system reset clears the packet queue);
  - counters return to 0.
- enable low mid-frame: the frame pauses and the timer still runs.

Test Plan:
- Good frame: bytes A5 03 00 11 22 33 66 -> wrreq pushes 11,22,33; load_1k pulses once after the 66 capture; pkt_count=1; wr_clear never asserts.
- Bad checksum: A5 02 00 01 02 04 -> wrreq pushes 01,02; wr_clear pulses once; load_1k=0; err_count=1.
- Length limits:
  - A5 00 00 -> ERR and no wrreq.
  - A5 01 04 (len=1025) -> ERR.
  - A5 00 04 with 1024 bytes of 01 and checksum 00 -> 1024 pushes, then load_1k.
- Garbage and backpressure: 00 FF 5A then a good frame -> garbage dropped, err_count=0. wrq_full held high for 10 cycles mid-payload -> rdreq stays low during the hold, with no lost or duplicated byte.
- Timeout with TIMEOUT_CYCLES=100: A5 05 00 AA, then rdq_empty held high -> wr_clear pulses exactly 100 cycles after the AA capture, state returns to HUNT, err_count=1.
- Reset mid-payload: assert reset during the 2nd payload byte -> all outputs 0 the next cycle; a following good frame is parsed normally.

Source files
------------

// File: rtl/ftdi_rx_packet_parser.sv
// Host byte stream framer: sync, length, payload, checksum.
// Streams payload into the 1 KiB packet queue and commits or discards it.
module ftdi_rx_packet_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 1024,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rdq_empty,
  input  logic [7:0]  data_rd,
  output logic        rdreq,
  input  logic        wrq_full,
  output logic [7:0]  data_wr,
  output logic        wrreq,
  output logic        load_1k,
  output logic        wr_clear,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_CSUM,
    S_GOOD,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          inflight_q, inflight_d;
  logic [10:0]   len_q, len_d;
  logic [10:0]   idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   pkt_q, pkt_d;
  logic [15:0]   err_q, err_d;

  logic          cap;
  logic          in_frame;
  logic          fetch_st;
  logic [10:0]   len_new;

  assign cap = inflight_q;

  always_comb begin
    in_frame = 1'b0;
    fetch_st = 1'b0;
    unique case (state_q)
      S_HUNT:    fetch_st = 1'b1;
      S_LEN_LO,
      S_LEN_HI,
      S_CSUM: begin
        fetch_st = 1'b1;
        in_frame = 1'b1;
      end
      S_PAYLOAD: begin
        fetch_st = !wrq_full;
        in_frame = 1'b1;
      end
      default: ;
    endcase
  end

  // A pop is only issued when nothing is in flight: one byte per 2 clocks.
  assign rdreq = !reset && enable && !rdq_empty && !inflight_q && fetch_st;

  assign wrreq    = cap && (state_q == S_PAYLOAD);
  assign data_wr  = wrreq ? data_rd : 8'h00;
  assign load_1k  = (state_q == S_GOOD);
  assign wr_clear = (state_q == S_ERR);
  assign busy     = (state_q != S_HUNT);

  assign pkt_count = pkt_q;
  assign err_count = err_q;

  always_comb begin
    state_d    = state_q;
    inflight_d = rdreq;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    timer_d    = '0;
    pkt_d      = pkt_q;
    err_d      = err_q;
    len_new    = {data_rd[2:0], len_q[7:0]};

    if (in_frame && !cap) begin
      timer_d = timer_q + 1'b1;
    end

    unique case (state_q)
      S_HUNT: begin
        if (cap && data_rd == SYNC_BYTE) begin
          state_d = S_LEN_LO;
          sum_d   = 8'h00;
          idx_d   = 11'd0;
        end
      end
      S_LEN_LO: begin
        if (cap) begin
          len_d   = {len_q[10:8], data_rd};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (cap) begin
          len_d = len_new;
          if (data_rd[7:3] != 5'd0 || len_new == 11'd0 ||
              {1'b0, len_new} > MAX_LEN_W) begin
            state_d = S_ERR;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (cap) begin
          sum_d = sum_q + data_rd;
          idx_d = idx_q + 11'd1;
          if (idx_q + 11'd1 == len_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (cap) begin
          state_d = (data_rd == sum_q) ? S_GOOD : S_ERR;
        end
      end
      S_GOOD: begin
        state_d = S_HUNT;
        if (pkt_q != 16'hFFFF) begin
          pkt_d = pkt_q + 16'd1;
        end
      end
      S_ERR: begin
        state_d = S_HUNT;
        if (err_q != 16'hFFFF) begin
          err_d = err_q + 16'd1;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // A byte captured in the expiry cycle still counts as progress.
    if (in_frame && !cap && timer_q == TIMER_LAST) begin
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_HUNT;
      inflight_q <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      timer_q    <= '0;
      pkt_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      timer_q    <= timer_d;
      pkt_q      <= pkt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ftdi_rx_packet_parser.sv
// Directed bench for ftdi_rx_packet_parser with a host FIFO model
// and a log of everything pushed into the packet queue.
module tb_ftdi_rx_packet_parser;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        hold_empty = 1'b0;
  logic        rdq_empty;
  logic [7:0]  data_rd = 8'h00;
  logic        rdreq;
  logic        wrq_full = 1'b0;
  logic [7:0]  data_wr;
  logic        wrreq;
  logic        load_1k;
  logic        wr_clear;
  logic        busy;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  logic [7:0] mem [0:4095];
  logic [7:0] wr_log [0:4095];
  int pushed = 0;
  int popped = 0;
  int underflow = 0;
  int wr_n = 0;
  int load_n = 0;
  int clr_n = 0;

  int n_assert = 0;
  int n_fail = 0;

  int wr0, ld0, cl0, bad, t;

  always #5 clk = ~clk;

  ftdi_rx_packet_parser #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN(1024),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clk),
    .reset(rst),
    .enable(enable),
    .rdq_empty(rdq_empty),
    .data_rd(data_rd),
    .rdreq(rdreq),
    .wrq_full(wrq_full),
    .data_wr(data_wr),
    .wrreq(wrreq),
    .load_1k(load_1k),
    .wr_clear(wr_clear),
    .busy(busy),
    .pkt_count(pkt_count),
    .err_count(err_count)
  );

  // Normal-mode host FIFO: data appears the cycle after rdreq.
  assign rdq_empty = hold_empty | (popped == pushed);

  always @(posedge clk) begin
    if (rdreq) begin
      if (popped == pushed) begin
        underflow <= underflow + 1;
      end else begin
        data_rd <= mem[popped[11:0]];
        popped  <= popped + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (wrreq) begin
      wr_log[wr_n[11:0]] <= data_wr;
      wr_n <= wr_n + 1;
    end
    if (load_1k) load_n <= load_n + 1;
    if (wr_clear) clr_n <= clr_n + 1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[pushed[11:0]] = b;
    pushed++;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((popped != pushed || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " drained"}, 32'(n < 5000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic snap();
    wr0 = wr_n;
    ld0 = load_n;
    cl0 = clr_n;
  endtask

  initial begin
    // Reset
    @(negedge clk);
    chk("rst rdreq", 32'(rdreq), 32'd0);
    chk("rst wrreq", 32'(wrreq), 32'd0);
    chk("rst load_1k", 32'(load_1k), 32'd0);
    chk("rst wr_clear", 32'(wr_clear), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst data_wr", 32'(data_wr), 32'd0);
    chk("rst pkt_count", 32'(pkt_count), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Good frame: 11+22+33 = 66
    snap();
    push(8'hA5); push(8'h03); push(8'h00);
    push(8'h11); push(8'h22); push(8'h33); push(8'h66);
    wait_idle("good");
    chk("good pushes", 32'(wr_n - wr0), 32'd3);
    chk("good byte0", 32'(wr_log[wr0[11:0]]), 32'h11);
    chk("good byte1", 32'(wr_log[12'(wr0 + 1)]), 32'h22);
    chk("good byte2", 32'(wr_log[12'(wr0 + 2)]), 32'h33);
    chk("good load_1k", 32'(load_n - ld0), 32'd1);
    chk("good wr_clear", 32'(clr_n - cl0), 32'd0);
    chk("good pkt_count", 32'(pkt_count), 32'd1);

    // Bad checksum: sum 03, sent 04
    snap();
    push(8'hA5); push(8'h02); push(8'h00);
    push(8'h01); push(8'h02); push(8'h04);
    wait_idle("badcs");
    chk("badcs pushes", 32'(wr_n - wr0), 32'd2);
    chk("badcs byte0", 32'(wr_log[wr0[11:0]]), 32'h01);
    chk("badcs byte1", 32'(wr_log[12'(wr0 + 1)]), 32'h02);
    chk("badcs wr_clear", 32'(clr_n - cl0), 32'd1);
    chk("badcs load_1k", 32'(load_n - ld0), 32'd0);
    chk("badcs err_count", 32'(err_count), 32'd1);

    // Zero length
    snap();
    push(8'hA5); push(8'h00); push(8'h00);
    wait_idle("len0");
    chk("len0 pushes", 32'(wr_n - wr0), 32'd0);
    chk("len0 wr_clear", 32'(clr_n - cl0), 32'd1);
    chk("len0 err_count", 32'(err_count), 32'd2);

    // Length 1025
    snap();
    push(8'hA5); push(8'h01); push(8'h04);
    wait_idle("len1025");
    chk("len1025 pushes", 32'(wr_n - wr0), 32'd0);
    chk("len1025 wr_clear", 32'(clr_n - cl0), 32'd1);
    chk("len1025 err_count", 32'(err_count), 32'd3);

    // Length 1024 of 01: sum 0x400 mod 256 = 00
    snap();
    push(8'hA5); push(8'h00); push(8'h04);
    for (int i = 0; i < 1024; i++) push(8'h01);
    push(8'h00);
    wait_idle("len1024");
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (wr_log[12'(wr0 + i)] !== 8'h01) bad++;
    end
    chk("len1024 pushes", 32'(wr_n - wr0), 32'd1024);
    chk("len1024 data", 32'(bad), 32'd0);
    chk("len1024 load_1k", 32'(load_n - ld0), 32'd1);
    chk("len1024 pkt_count", 32'(pkt_count), 32'd2);

    // Garbage then good frame: 10+20 = 30
    snap();
    push(8'h00); push(8'hFF); push(8'h5A);
    push(8'hA5); push(8'h02); push(8'h00);
    push(8'h10); push(8'h20); push(8'h30);
    wait_idle("garbage");
    chk("garbage pushes", 32'(wr_n - wr0), 32'd2);
    chk("garbage byte0", 32'(wr_log[wr0[11:0]]), 32'h10);
    chk("garbage byte1", 32'(wr_log[12'(wr0 + 1)]), 32'h20);
    chk("garbage err_count", 32'(err_count), 32'd3);
    chk("garbage pkt_count", 32'(pkt_count), 32'd3);

    // Backpressure after 2nd payload byte: 1+2+3+4 = 0A
    snap();
    push(8'hA5); push(8'h04); push(8'h00);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h0A);
    t = 0;
    while (!(wrreq && data_wr == 8'h02) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp reach byte2", 32'(t < 100), 32'd1);
    wrq_full = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdreq !== 1'b0) bad++;
    end
    chk("bp rdreq held low", 32'(bad), 32'd0);
    wrq_full = 1'b0;
    wait_idle("bp");
    chk("bp pushes", 32'(wr_n - wr0), 32'd4);
    chk("bp byte2", 32'(wr_log[12'(wr0 + 2)]), 32'h03);
    chk("bp byte3", 32'(wr_log[12'(wr0 + 3)]), 32'h04);
    chk("bp load_1k", 32'(load_n - ld0), 32'd1);
    chk("bp pkt_count", 32'(pkt_count), 32'd4);

    // Enable low: no pop
    enable = 1'b0;
    t = popped;
    push(8'h00);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdreq !== 1'b0) bad++;
    end
    chk("enable rdreq", 32'(bad), 32'd0);
    chk("enable no pop", 32'(popped - t), 32'd0);
    enable = 1'b1;
    wait_idle("enable");

    // Timeout: AA is registered at the edge closing its capture
    // cycle; the abort pulse follows that edge by TO clocks.
    snap();
    push(8'hA5); push(8'h05); push(8'h00); push(8'hAA);
    t = 0;
    while (!(wrreq && data_wr == 8'hAA) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("to reach AA", 32'(t < 100), 32'd1);
    bad = 0;
    t = 0;
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k <= TO && wr_clear) bad++;
      if (k == TO + 1) t = 32'(wr_clear);
    end
    chk("to early clear", 32'(bad), 32'd0);
    chk("to clear on time", 32'(t), 32'd1);
    @(negedge clk);
    chk("to busy", 32'(busy), 32'd0);
    chk("to err_count", 32'(err_count), 32'd4);
    chk("to load_1k", 32'(load_n - ld0), 32'd0);

    // Reset during 2nd payload byte
    snap();
    push(8'hA5); push(8'h03); push(8'h00);
    push(8'h11); push(8'h22); push(8'h33); push(8'h66);
    t = 0;
    while (!(wrreq && data_wr == 8'h22) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mrst reach byte2", 32'(t < 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst rdreq", 32'(rdreq), 32'd0);
    chk("mrst wrreq", 32'(wrreq), 32'd0);
    chk("mrst load_1k", 32'(load_1k), 32'd0);
    chk("mrst wr_clear", 32'(wr_clear), 32'd0);
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst data_wr", 32'(data_wr), 32'd0);
    chk("mrst pkt_count", 32'(pkt_count), 32'd0);
    chk("mrst err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    wait_idle("mrst flush");
    snap();
    push(8'hA5); push(8'h01); push(8'h00); push(8'h7E); push(8'h7E);
    wait_idle("mrst good");
    chk("mrst pushes", 32'(wr_n - wr0), 32'd1);
    chk("mrst byte0", 32'(wr_log[wr0[11:0]]), 32'h7E);
    chk("mrst pkt_count", 32'(pkt_count), 32'd1);
    chk("mrst err_count 2", 32'(err_count), 32'd0);
    chk("mrst wr_clear", 32'(clr_n - cl0), 32'd0);
    chk("fifo underflow", 32'(underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
